// File: rtl/stm32_iq_stream_tx.sv
// Multi-channel RX I/Q frame streamer toward the STM32 through the 32-bit BUS_SPI serialiser.
// Sample sets are buffered as frames. Each frame is sent as a header word followed by the
// I and Q words of every channel that was enabled when the frame left the FIFO.
module stm32_iq_stream_tx #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned SAMPLE_W   = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic                         clk_in,
   input  logic                         reset_n,
   input  logic                         iq_valid,
   input  logic [NUM_CH*SAMPLE_W-1:0]   RX_I,
   input  logic [NUM_CH*SAMPLE_W-1:0]   RX_Q,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic                         BUS_SPI_busy,
   output logic [31:0]                  BUS_SPI_data_out,
   output logic                         BUS_SPI_enable,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic [15:0]                  overrun_count,
   output logic [15:0]                  timeout_count,
   output logic                         stream_active
);

   localparam int unsigned FRAME_W = NUM_CH * SAMPLE_W;
   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned LW      = AW + 1;
   localparam int unsigned TW      = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_REQ, S_WBUSY, S_WDONE, S_GAP} state_t;

   state_t              state, state_d;
   logic [FRAME_W-1:0]  mem_i [FIFO_DEPTH];
   logic [FRAME_W-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [FRAME_W-1:0]  frame_i, frame_q;
   logic [NUM_CH-1:0]   rem_mask, rem_d;
   logic                q_pend, q_pend_d;
   logic [31:0]         q_hold, q_hold_d;
   logic [7:0]          seq, seq_d;
   logic                ovr_flag, hdr_clr;
   logic [TW-1:0]       tmo_cnt, tmo_d;
   logic [31:0]         data_d;
   logic                en_d, act_d;
   logic [15:0]         tcnt_d;
   logic                pop, push, drop, push_req, full;
   logic [31:0]         sel_i, sel_q;
   logic [NUM_CH-1:0]   sel_clr;

   function automatic logic [31:0] sext(input logic [SAMPLE_W-1:0] v);
      return 32'($signed(v));
   endfunction

   assign push_req = iq_valid && (ch_enable != '0);
   assign full     = (fifo_level == LW'(FIFO_DEPTH));

   // State register
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_d;
   end

   // Next-state, next output word and frame bookkeeping
   always_comb begin
      state_d  = state;
      data_d   = BUS_SPI_data_out;
      en_d     = BUS_SPI_enable;
      act_d    = stream_active;
      seq_d    = seq;
      rem_d    = rem_mask;
      q_pend_d = q_pend;
      q_hold_d = q_hold;
      tmo_d    = tmo_cnt;
      tcnt_d   = timeout_count;
      hdr_clr  = 1'b0;
      pop      = 1'b0;
      sel_i    = '0;
      sel_q    = '0;
      sel_clr  = '0;
      // Descending scan leaves the lowest remaining channel selected
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (rem_mask[c]) begin
            sel_i      = sext(frame_i[c*SAMPLE_W +: SAMPLE_W]);
            sel_q      = sext(frame_q[c*SAMPLE_W +: SAMPLE_W]);
            sel_clr    = '0;
            sel_clr[c] = 1'b1;
         end
      end
      case (state)
         S_IDLE: begin
            if (fifo_level != '0) begin
               pop      = 1'b1;
               act_d    = 1'b1;
               rem_d    = ch_enable;
               q_pend_d = 1'b0;
               state_d  = S_HDR;
            end
         end
         S_HDR: begin
            data_d  = {16'hA55A, seq, 4'(rem_mask), ovr_flag, 3'b000};
            hdr_clr = 1'b1;
            seq_d   = seq + 8'd1;
            state_d = S_REQ;
         end
         S_REQ: begin
            en_d    = 1'b1;
            tmo_d   = '0;
            state_d = S_WBUSY;
         end
         S_WBUSY, S_WDONE: begin
            if ((state == S_WBUSY) == BUS_SPI_busy) begin
               tmo_d = '0;
               if (state == S_WBUSY) begin
                  state_d = S_WDONE;
               end else begin
                  en_d    = 1'b0;
                  state_d = S_GAP;
               end
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               en_d    = 1'b0;
               act_d   = 1'b0;
               tcnt_d  = (timeout_count == 16'hFFFF) ? timeout_count : timeout_count + 16'd1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_cnt + TW'(1);
            end
         end
         S_GAP: begin
            if (q_pend) begin
               data_d   = q_hold;
               q_pend_d = 1'b0;
               state_d  = S_REQ;
            end else if (rem_mask != '0) begin
               data_d   = sel_i;
               q_hold_d = sel_q;
               rem_d    = rem_mask & ~sel_clr;
               q_pend_d = 1'b1;
               state_d  = S_REQ;
            end else begin
               act_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      push = push_req && (!full || pop);
      drop = push_req && !push;
   end

   // Registered outputs, FIFO pointers and frame registers
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         BUS_SPI_data_out <= '0;
         BUS_SPI_enable   <= 1'b0;
         stream_active    <= 1'b0;
         fifo_level       <= '0;
         overrun_count    <= '0;
         timeout_count    <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         frame_i          <= '0;
         frame_q          <= '0;
         rem_mask         <= '0;
         q_pend           <= 1'b0;
         q_hold           <= '0;
         seq              <= '0;
         ovr_flag         <= 1'b0;
         tmo_cnt          <= '0;
      end else begin
         BUS_SPI_data_out <= data_d;
         BUS_SPI_enable   <= en_d;
         stream_active    <= act_d;
         timeout_count    <= tcnt_d;
         rem_mask         <= rem_d;
         q_pend           <= q_pend_d;
         q_hold           <= q_hold_d;
         seq              <= seq_d;
         tmo_cnt          <= tmo_d;
         ovr_flag         <= (ovr_flag & ~hdr_clr) | drop;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            frame_i <= mem_i[rd_ptr];
            frame_q <= mem_q[rd_ptr];
         end
         if (push && !pop)      fifo_level <= fifo_level + LW'(1);
         else if (pop && !push) fifo_level <= fifo_level - LW'(1);
         if (drop && (overrun_count != 16'hFFFF)) overrun_count <= overrun_count + 16'd1;
      end
   end

   // Frame storage
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_i[wr_ptr] <= RX_I;
         mem_q[wr_ptr] <= RX_Q;
      end
   end

endmodule
